// File: rtl/ecc_kp_scheduler.sv
// Left-to-right double-and-add sequencer for kP: scans the key and drives LOAD/DBL/ADD
// commands to the shared point datapath. Define ECC_CONST_TIME_EN for constant-time mode.
module ecc_kp_scheduler #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_k,
  input  logic            i_op_ready,
  input  logic            i_op_done,
  output logic            o_op_valid,
  output logic [1:0]      o_op_code,
  output logic            o_op_dummy,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_inf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_DBL  = 2'b01,
    OP_ADD  = 2'b10
  } op_t;

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0]  K_ZERO   = {SIZE{1'b0}};

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [SIZE-1:0]  k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             inf_q, inf_d;
  logic             k_zero_s;
  logic             scan_done_s;
  logic             add_needed_s;

  assign k_zero_s = (k_q == K_ZERO);

`ifdef ECC_CONST_TIME_EN
  logic [CNT_W-1:0] scan_q, scan_d;
  logic             dummy_q, dummy_d;

  // Scan length is fixed; k_q normalises silently and is only judged on the last cycle.
  assign scan_done_s  = (scan_q == CNT_ZERO);
  assign add_needed_s = 1'b1;
  assign o_op_dummy   = dummy_q;
`else
  assign scan_done_s  = k_zero_s | k_q[SIZE-1];
  assign add_needed_s = k_q[SIZE-1];
  assign o_op_dummy   = 1'b0;
`endif

  assign o_op_valid = valid_q;
  assign o_op_code  = op_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_inf      = inf_q;

  // Next-state and next-output logic for the scan/issue/wait sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    inf_d   = inf_q;
`ifdef ECC_CONST_TIME_EN
    scan_d  = scan_q;
    dummy_d = dummy_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = i_k;
          cnt_d   = CNT_TOP;
          inf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
`ifdef ECC_CONST_TIME_EN
          scan_d  = CNT_TOP;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
`ifdef ECC_CONST_TIME_EN
        scan_d = scan_done_s ? CNT_ZERO : (scan_q - CNT_ONE);
`endif
        if (scan_done_s) begin
          if (k_zero_s) begin
            inf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            op_d    = OP_LOAD;
            valid_d = 1'b1;
            state_d = S_ISSUE;
`ifdef ECC_CONST_TIME_EN
            dummy_d = 1'b0;
`endif
          end
        end else if (!k_q[SIZE-1] && !k_zero_s) begin
          k_d   = {k_q[SIZE-2:0], 1'b0};
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          k_d = k_q;
        end
      end
      S_ISSUE: begin
        if (i_op_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end else begin
          valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_op_done) begin
          if ((op_q == OP_DBL) && add_needed_s) begin
            op_d    = OP_ADD;
            valid_d = 1'b1;
            state_d = S_ISSUE;
`ifdef ECC_CONST_TIME_EN
            dummy_d = ~k_q[SIZE-1];
`endif
          end else if (cnt_q == CNT_ZERO) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            // Shift before the DBL so the bit it serves sits at the top of k_q.
            k_d     = {k_q[SIZE-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_ONE;
            op_d    = OP_DBL;
            valid_d = 1'b1;
            state_d = S_ISSUE;
`ifdef ECC_CONST_TIME_EN
            dummy_d = 1'b0;
`endif
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      k_q     <= K_ZERO;
      cnt_q   <= CNT_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inf_q   <= 1'b0;
`ifdef ECC_CONST_TIME_EN
      scan_q  <= CNT_ZERO;
      dummy_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inf_q   <= inf_d;
`ifdef ECC_CONST_TIME_EN
      scan_q  <= scan_d;
      dummy_q <= dummy_d;
`endif
    end
  end

endmodule

// File: tb/tb_ecc_kp_scheduler.sv
// Self-checking bench for ecc_kp_scheduler: a transaction-level model predicts the op list
// and handshake timing from the key; a responder plays the datapath.
module tb_ecc_kp_scheduler;

  localparam int SIZE  = 32;
  localparam int CNT_W = 5;
  localparam int PH_IDLE = 0, PH_SCAN = 1, PH_ISSUE = 2, PH_WAIT = 3, PH_DONE = 4;
  localparam int LIMIT = 4000;

  logic            clk;
  logic            i_rst;
  logic            i_start;
  logic [SIZE-1:0] i_k;
  logic            i_op_ready;
  logic            i_op_done;
  logic            o_op_valid;
  logic [1:0]      o_op_code;
  logic            o_op_dummy;
  logic            o_busy;
  logic            o_done;
  logic            o_inf;

  int         n_checks = 0;
  int         n_err = 0;
  int         ph = PH_IDLE;
  int         ph_cnt = 0;
  int         timer = 0;
  int         hold_cnt = 0;
  int         hold_cyc = 0;
  int         done_lat = 2;
  bit         rdy_rand = 1'b0;
  bit         noise = 1'b0;
  logic       last_inf = 1'b0;
  logic       run_inf = 1'b0;
  logic [1:0] prev_code = 2'b00;
  logic       prev_dummy = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_all[$];
  logic [2:0] got_q[$];

  ecc_kp_scheduler #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_k        (i_k),
    .i_op_ready (i_op_ready),
    .i_op_done  (i_op_done),
    .o_op_valid (o_op_valid),
    .o_op_code  (o_op_code),
    .o_op_dummy (o_op_dummy),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_inf      (o_inf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int msb_of(input logic [SIZE-1:0] k);
    int m;
    m = -1;
    for (int b = 0; b < SIZE; b++) if (k[b]) m = b;
    return m;
  endfunction

  // Cycles the block spends scanning before its first command or done pulse.
  function automatic int scan_len(input logic [SIZE-1:0] k);
`ifdef ECC_CONST_TIME_EN
    return SIZE + 0 * msb_of(k);
`else
    if (k == '0) return 1;
    return SIZE - msb_of(k);
`endif
  endfunction

  // Expected command list, entries are {dummy, code}.
  function automatic void model_build(input logic [SIZE-1:0] k);
    int m;
    exp_q.delete();
    m = msb_of(k);
    if (m >= 0) begin
      exp_q.push_back(3'b000);
      for (int b = m - 1; b >= 0; b--) begin
        exp_q.push_back(3'b001);
`ifdef ECC_CONST_TIME_EN
        exp_q.push_back({~k[b], 2'b10});
`else
        if (k[b]) exp_q.push_back(3'b010);
`endif
      end
    end
    exp_all = exp_q;
  endfunction

  function automatic logic [63:0] pack_list(input bit use_got);
    logic [63:0] v;
    v = 64'd0;
    if (use_got) foreach (got_q[i]) v = (v << 3) | 64'(got_q[i]);
    else foreach (exp_all[i]) v = (v << 3) | 64'(exp_all[i]);
    return v;
  endfunction

  function automatic int count_adds();
    int n;
    n = 0;
    foreach (got_q[i]) if (got_q[i][1:0] == 2'b10) n++;
    return n;
  endfunction

  // Per-cycle comparison against the model, then datapath responder drive.
  initial begin : mon
    int ph_prev;
    logic [2:0] e;
    i_op_ready = 1'b0;
    i_op_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph_prev = ph;
      if (!i_rst) begin
        chk("rst_outputs", 64'({o_op_valid, o_op_code, o_op_dummy, o_busy, o_done, o_inf}), 64'd0);
        ph = PH_IDLE;
        exp_q.delete();
        timer = 0;
        last_inf = 1'b0;
      end else begin
        case (ph)
          PH_IDLE: if (i_start) begin
            model_build(i_k);
            run_inf  = (i_k == '0);
            ph_cnt   = scan_len(i_k);
            got_q.delete();
            last_inf = 1'b0;
            ph = PH_SCAN;
          end
          PH_SCAN: begin
            ph_cnt--;
            if (ph_cnt == 0) begin
              if (exp_q.size() == 0) begin
                ph = PH_DONE;
                last_inf = run_inf;
              end else ph = PH_ISSUE;
            end
          end
          PH_ISSUE: if (i_op_ready) begin
            got_q.push_back({prev_dummy, prev_code});
            void'(exp_q.pop_front());
            ph = PH_WAIT;
            timer = done_lat;
          end
          PH_WAIT: if (i_op_done) begin
            if (exp_q.size() == 0) begin
              ph = PH_DONE;
              last_inf = run_inf;
            end else ph = PH_ISSUE;
          end
          default: ph = PH_IDLE;
        endcase
        chk("op_valid", 64'(o_op_valid), 64'(ph == PH_ISSUE));
        chk("busy", 64'(o_busy), 64'(ph != PH_IDLE));
        chk("done", 64'(o_done), 64'(ph == PH_DONE));
        chk("inf", 64'(o_inf), 64'(last_inf));
        if (ph == PH_ISSUE) begin
          e = exp_q[0];
          chk("op_code", 64'(o_op_code), 64'(e[1:0]));
          chk("op_dummy", 64'(o_op_dummy), 64'(e[2]));
        end
      end
      prev_code  = o_op_code;
      prev_dummy = o_op_dummy;
      i_op_done = 1'b0;
      if (ph == PH_WAIT) begin
        if (timer > 0) begin
          timer--;
          if (timer == 0) i_op_done = 1'b1;
        end
      end else begin
        i_op_done = noise;
      end
      if (ph == PH_ISSUE) begin
        if (ph_prev != PH_ISSUE) hold_cnt = 0;
        i_op_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : (hold_cnt >= hold_cyc);
        hold_cnt++;
      end else begin
        i_op_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (ph != PH_IDLE && g < LIMIT) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", 64'(g < LIMIT), 64'd1);
  endtask

  task automatic run_k(input logic [SIZE-1:0] k);
    wait_idle();
    i_k = k;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_k = SIZE'($urandom());
    wait_idle();
    chk("op_count", 64'(got_q.size()), 64'(exp_all.size()));
  endtask

  initial begin : main
    logic [SIZE-1:0] kk;
    int g;
    i_rst = 1'b0;
    i_start = 1'b0;
    i_k = '0;

    // Hand-computed pins on the model itself.
    model_build(SIZE'(32'd6));
`ifdef ECC_CONST_TIME_EN
    chk("model_k6", pack_list(1'b0), 64'h28E);
    chk("model_scan_k0", 64'(scan_len(SIZE'(32'd0))), 64'd32);
`else
    chk("model_k6", pack_list(1'b0), 64'h051);
    chk("model_scan_k0", 64'(scan_len(SIZE'(32'd0))), 64'd1);
`endif
    chk("model_scan_k1", 64'(scan_len(SIZE'(32'd1))), 64'd32);

    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);

    run_k(SIZE'(32'd0));
    chk("k0_ops", 64'(got_q.size()), 64'd0);
    chk("k0_inf", 64'(o_inf), 64'd1);

    run_k(SIZE'(32'd1));
    chk("k1_seq", pack_list(1'b1), 64'h0);
    chk("k1_len", 64'(got_q.size()), 64'd1);
    chk("k1_inf", 64'(o_inf), 64'd0);

    run_k(SIZE'(32'd6));
`ifdef ECC_CONST_TIME_EN
    chk("k6_seq", pack_list(1'b1), 64'h28E);
`else
    chk("k6_seq", pack_list(1'b1), 64'h051);
`endif

    run_k(SIZE'(32'h8000_0000));
`ifdef ECC_CONST_TIME_EN
    chk("msb_len", 64'(got_q.size()), 64'd63);
    chk("msb_adds", 64'(count_adds()), 64'd31);
`else
    chk("msb_len", 64'(got_q.size()), 64'd32);
    chk("msb_adds", 64'(count_adds()), 64'd0);
`endif

    // Backpressure plus done pulses injected outside WAIT.
    hold_cyc = 3;
    noise = 1'b1;
    run_k(SIZE'(32'd3));
    chk("k3_seq", pack_list(1'b1), 64'h0A);
    hold_cyc = 0;
    noise = 1'b0;

    // Second start while busy must be ignored.
    wait_idle();
    i_k = SIZE'(32'd5);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    i_k = '0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle();
`ifdef ECC_CONST_TIME_EN
    chk("k5_seq", pack_list(1'b1), 64'h38A);
`else
    chk("k5_seq", pack_list(1'b1), 64'h04A);
`endif
    chk("k5_inf", 64'(o_inf), 64'd0);

    // Reset while waiting on the datapath.
    done_lat = 4;
    i_k = SIZE'(32'd6);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    g = 0;
    while (ph != PH_WAIT && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("reach_wait", 64'(g < 200), 64'd1);
    i_rst = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    repeat (10) @(negedge clk);

    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: kk = SIZE'($urandom());
        1: kk = SIZE'($urandom_range(0, 15));
        2: kk = SIZE'(32'd1) << $urandom_range(0, SIZE - 1);
        default: kk = SIZE'($urandom()) >> $urandom_range(0, SIZE - 1);
      endcase
      done_lat = $urandom_range(1, 4);
      rdy_rand = ($urandom_range(0, 1) == 1);
      noise = ($urandom_range(0, 1) == 1);
      run_k(kk);
    end
    noise = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
